// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: takes one parallel SRAM read/write request at a time and
// sends it to the SPI slave as a command bit, an 8-bit address and 8 data
// bits, MSB first. For reads it captures the 8-bit reply from the slave.
module spi_master_ctrl #(
    parameter int TURNAROUND = 2,
    parameter int IDLE_GAP   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_cmd,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       sdoM,
    input  logic       sdoS,
    output logic       frame,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       wr_done
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        TURN,
        RDATA,
        GAP
    } state_t;

    localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);
    localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP - 1);

    state_t      state_q, state_d;
    logic        cmd_q, cmd_d;
    logic [15:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  turn_cnt_q, turn_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        sdo_m_q, sdo_m_d;
    logic        frame_q, frame_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        wr_done_q, wr_done_d;

    // Register the FSM, shift registers, counters and every serial output.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= 1'b0;
            tx_q        <= 16'h0000;
            rx_q        <= 8'h00;
            bit_cnt_q   <= 3'd0;
            turn_cnt_q  <= 4'd0;
            gap_cnt_q   <= 4'd0;
            sdo_m_q     <= 1'b0;
            frame_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            bit_cnt_q   <= bit_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            sdo_m_q     <= sdo_m_d;
            frame_q     <= frame_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            wr_done_q   <= wr_done_d;
        end
    end

    // Next-state logic; sdoM/frame are computed for the upcoming cycle so they leave the chip straight from flops.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        turn_cnt_d  = turn_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        sdo_m_d     = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        wr_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d   = CMD;
                    cmd_d     = req_cmd;
                    tx_d      = {req_addr, req_data};
                    bit_cnt_d = 3'd0;
                    sdo_m_d   = req_cmd;
                end
            end
            CMD: begin
                state_d   = ADDR;
                bit_cnt_d = 3'd0;
                sdo_m_d   = tx_q[15];
                tx_d      = {tx_q[14:0], 1'b0};
            end
            ADDR: begin
                if (bit_cnt_q == 3'd7) begin
                    bit_cnt_d = 3'd0;
                    if (cmd_q) begin
                        state_d = DATA;
                        sdo_m_d = tx_q[15];
                        tx_d    = {tx_q[14:0], 1'b0};
                    end else begin
                        state_d    = TURN;
                        turn_cnt_d = 4'd0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    sdo_m_d   = tx_q[15];
                    tx_d      = {tx_q[14:0], 1'b0};
                end
            end
            DATA: begin
                if (bit_cnt_q == 3'd7) begin
                    state_d   = GAP;
                    bit_cnt_d = 3'd0;
                    gap_cnt_d = 4'd0;
                    wr_done_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    sdo_m_d   = tx_q[15];
                    tx_d      = {tx_q[14:0], 1'b0};
                end
            end
            TURN: begin
                if (turn_cnt_q == TURN_LAST) begin
                    state_d   = RDATA;
                    bit_cnt_d = 3'd0;
                end else begin
                    turn_cnt_d = turn_cnt_q + 4'd1;
                end
            end
            RDATA: begin
                rx_d = {rx_q[6:0], sdoS};
                if (bit_cnt_q == 3'd7) begin
                    state_d     = GAP;
                    bit_cnt_d   = 3'd0;
                    gap_cnt_d   = 4'd0;
                    rsp_data_d  = {rx_q[6:0], sdoS};
                    rsp_valid_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        frame_d = (state_d != IDLE) && (state_d != GAP);
    end

    // Drive the ports from state and output flops only.
    always_comb begin
        req_ready = (state_q == IDLE);
        sdoM      = sdo_m_q;
        frame     = frame_q;
        rsp_valid = rsp_valid_q;
        rsp_data  = rsp_data_q;
        wr_done   = wr_done_q;
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: three spi_master_ctrl instances with different
// turnaround/gap settings, each attached to an SRAM slave model.
module tb_spi_master_ctrl;

    localparam int TURN0 = 2;
    localparam int TURN1 = 1;
    localparam int TURN2 = 5;
    localparam int GAP0  = 1;
    localparam int GAP1  = 3;
    localparam int GAP2  = 3;

    typedef struct {
        int         dut;
        logic       cmd;
        logic [7:0] addr;
        logic [7:0] data;
        int         mode;
        logic [7:0] exp_rsp;
    } vec_t;

    logic       clock;
    logic       reset;
    logic       req_valid [3];
    logic       req_cmd   [3];
    logic [7:0] req_addr  [3];
    logic [7:0] req_data  [3];
    logic       req_ready [3];
    logic       sdo_m     [3];
    logic       frame_w   [3];
    logic       rsp_valid [3];
    logic [7:0] rsp_data  [3];
    logic       wr_done   [3];

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  ref_mem  [3][256];
    logic [7:0]  last_rsp [3];
    logic [63:0] exp_sdo, exp_frame, exp_ready, exp_done, exp_valid;
    logic [63:0] act_sdo, act_frame, act_ready, act_done, act_valid;
    logic [7:0]  act_rsp;
    logic        hs_ok;
    int          exp_len;
    int          exp_rsp_k;
    vec_t        vecs [9];

    function automatic int turn_of(input int i);
        return (i == 0) ? TURN0 : (i == 1) ? TURN1 : TURN2;
    endfunction

    function automatic int gap_of(input int i);
        return (i == 0) ? GAP0 : (i == 1) ? GAP1 : GAP2;
    endfunction

    // Power-on SRAM contents; instance 0 holds mem[a] = a.
    function automatic logic [7:0] mem_init(input int g, input int a);
        return 8'(a) ^ 8'(g * 'h5A);
    endfunction

    initial clock = 1'b0;
    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int T = (g == 0) ? TURN0 : (g == 1) ? TURN1 : TURN2;
        localparam int G = (g == 0) ? GAP0 : (g == 1) ? GAP1 : GAP2;
        logic       sdo_s;
        logic [7:0] slave_mem [256];

        spi_master_ctrl #(.TURNAROUND(T), .IDLE_GAP(G)) u_dut (
            .clock    (clock),
            .reset    (reset),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_cmd  (req_cmd[g]),
            .req_addr (req_addr[g]),
            .req_data (req_data[g]),
            .sdoM     (sdo_m[g]),
            .sdoS     (sdo_s),
            .frame    (frame_w[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_data (rsp_data[g]),
            .wr_done  (wr_done[g])
        );

        // SRAM slave: decodes the frame bit by bit and returns read data after the turnaround.
        initial begin : slave
            int         n;
            logic       s_cmd;
            logic [7:0] s_addr;
            logic [7:0] s_data;
            for (int a = 0; a < 256; a++) slave_mem[a] = mem_init(g, a);
            n      = 0;
            s_cmd  = 1'b0;
            s_addr = 8'h00;
            s_data = 8'h00;
            sdo_s  = 1'b0;
            forever begin
                @(negedge clock);
                sdo_s = 1'($urandom);
                if (frame_w[g]) begin
                    if (n == 0) begin
                        s_cmd = sdo_m[g];
                    end else if (n <= 8) begin
                        s_addr = {s_addr[6:0], sdo_m[g]};
                    end else if (s_cmd && n <= 16) begin
                        s_data = {s_data[6:0], sdo_m[g]};
                        if (n == 16) slave_mem[s_addr] = s_data;
                    end else if (!s_cmd && n >= 9 + T && n <= 16 + T) begin
                        sdo_s = slave_mem[s_addr][16 + T - n];
                    end
                    n++;
                end else begin
                    n = 0;
                end
            end
        end
    end

    // Hard stop in case something hangs.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Cycle-by-cycle picture of a frame, counted from the cycle after the handshake.
    task automatic expectTrace(input int i, input logic cmd, input logic [7:0] addr, input logic [7:0] data);
        int t;
        int g;
        int body;
        t = turn_of(i);
        g = gap_of(i);
        body = cmd ? 17 : 17 + t;
        exp_len   = body + 1 + g;
        exp_rsp_k = cmd ? exp_len : 18 + t;
        exp_sdo = '0; exp_frame = '0; exp_ready = '0; exp_done = '0; exp_valid = '0;
        for (int k = 1; k <= exp_len; k++) begin
            exp_frame[k] = (k <= body);
            if (k == 1) exp_sdo[k] = cmd;
            else if (k <= 9) exp_sdo[k] = addr[9 - k];
            else if (cmd && k <= 17) exp_sdo[k] = data[17 - k];
            exp_ready[k] = (k == exp_len);
            exp_done[k]  = cmd && (k == 18);
            exp_valid[k] = !cmd && (k == 18 + t);
        end
    endtask

    // mode 0: drop req_valid after handshake; 1: hold it high; 2: random junk while busy.
    task automatic applyStimulus(input int i, input logic cmd, input logic [7:0] addr, input logic [7:0] data, input int mode);
        int waited;
        hs_ok = 1'b0;
        act_sdo = '0; act_frame = '0; act_ready = '0; act_done = '0; act_valid = '0;
        act_rsp = 8'h00;
        req_valid[i] = 1'b1;
        req_cmd[i]   = cmd;
        req_addr[i]  = addr;
        req_data[i]  = data;
        waited = 0;
        while (req_ready[i] !== 1'b1 && waited < 64) begin
            @(negedge clock);
            waited++;
        end
        if (req_ready[i] !== 1'b1) begin
            req_valid[i] = 1'b0;
            return;
        end
        hs_ok = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= exp_len; k++) begin
            @(negedge clock);
            act_sdo[k]   = sdo_m[i];
            act_frame[k] = frame_w[i];
            act_ready[k] = req_ready[i];
            act_done[k]  = wr_done[i];
            act_valid[k] = rsp_valid[i];
            if (k == exp_rsp_k) act_rsp = rsp_data[i];
            if (k == exp_len) begin
                if (mode != 1) req_valid[i] = 1'b0;
            end else if (mode == 2) begin
                req_valid[i] = 1'($urandom);
                req_cmd[i]   = 1'($urandom);
                req_addr[i]  = 8'($urandom);
                req_data[i]  = 8'($urandom);
            end
        end
    endtask

    // One transaction: build the expected picture, run it, compare, update the model.
    task automatic runVec(input int i, input logic cmd, input logic [7:0] addr, input logic [7:0] data,
                          input int mode, input logic use_exp, input logic [7:0] exp_rsp, input string tag);
        logic [7:0] want;
        expectTrace(i, cmd, addr, data);
        want = cmd ? last_rsp[i] : (use_exp ? exp_rsp : ref_mem[i][addr]);
        applyStimulus(i, cmd, addr, data, mode);
        checkOutput({tag, " handshake"}, 64'(hs_ok), 64'd1);
        if (hs_ok) begin
            checkOutput({tag, " sdoM"},      act_sdo,   exp_sdo);
            checkOutput({tag, " frame"},     act_frame, exp_frame);
            checkOutput({tag, " req_ready"}, act_ready, exp_ready);
            checkOutput({tag, " wr_done"},   act_done,  exp_done);
            checkOutput({tag, " rsp_valid"}, act_valid, exp_valid);
            checkOutput({tag, " rsp_data"},  64'(act_rsp), 64'(want));
        end
        if (cmd) ref_mem[i][addr] = data;
        else     last_rsp[i] = ref_mem[i][addr];
    endtask

    // Main sequence: reset, directed table, abort by reset, random traffic.
    initial begin
        int pulses;
        int m;
        logic c;

        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_cmd[i]   = 1'b0;
            req_addr[i]  = 8'h00;
            req_data[i]  = 8'h00;
            last_rsp[i]  = 8'h00;
            for (int a = 0; a < 256; a++) ref_mem[i][a] = mem_init(i, a);
        end

        vecs[0] = '{0, 1'b1, 8'h1F, 8'hA5, 0, 8'h00};
        vecs[1] = '{0, 1'b0, 8'h32, 8'h00, 0, 8'h32};
        vecs[2] = '{0, 1'b1, 8'h31, 8'h7E, 1, 8'h00};
        vecs[3] = '{0, 1'b0, 8'h31, 8'h00, 0, 8'h7E};
        vecs[4] = '{0, 1'b0, 8'h1F, 8'h00, 2, 8'hA5};
        vecs[5] = '{1, 1'b1, 8'h40, 8'hC3, 1, 8'h00};
        vecs[6] = '{1, 1'b0, 8'h40, 8'h00, 0, 8'hC3};
        vecs[7] = '{2, 1'b1, 8'h41, 8'h3C, 1, 8'h00};
        vecs[8] = '{2, 1'b0, 8'h41, 8'h00, 2, 8'h3C};

        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset state dut%0d", i),
                        64'({req_ready[i], frame_w[i], sdo_m[i], rsp_valid[i], wr_done[i], rsp_data[i]}),
                        64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
        end

        for (int v = 0; v < 9; v++) begin
            runVec(vecs[v].dut, vecs[v].cmd, vecs[v].addr, vecs[v].data, vecs[v].mode,
                   !vecs[v].cmd, vecs[v].exp_rsp, $sformatf("vec%0d", v));
        end

        // Abort a read in its address phase with a one-cycle reset.
        req_valid[0] = 1'b1;
        req_cmd[0]   = 1'b0;
        req_addr[0]  = 8'h55;
        @(posedge clock);
        @(negedge clock);
        req_valid[0] = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("reset abort outputs",
                    64'({frame_w[0], sdo_m[0], req_ready[0], rsp_valid[0], rsp_data[0]}),
                    64'({1'b0, 1'b0, 1'b1, 1'b0, 8'h00}));
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (rsp_valid[0] || wr_done[0] || frame_w[0]) pulses++;
        end
        checkOutput("reset abort no activity", 64'(pulses), 64'd0);
        for (int i = 0; i < 3; i++) last_rsp[i] = 8'h00;
        runVec(0, 1'b1, 8'h55, 8'h99, 0, 1'b0, 8'h00, "post-reset write");
        runVec(0, 1'b0, 8'h55, 8'h00, 0, 1'b1, 8'h99, "post-reset read");

        // Random traffic on a small address window so reads hit earlier writes.
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 10; n++) begin
                c = 1'($urandom);
                m = (n == 9) ? 0 : int'($urandom_range(0, 2));
                runVec(i, c, 8'h60 + 8'($urandom_range(0, 7)), 8'($urandom), m, 1'b0, 8'h00,
                       $sformatf("rand dut%0d #%0d", i, n));
            end
        end

        repeat (4) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
